// File: rtl/seven_segment_scan_ctrl.sv
// Four-digit common-anode scan controller: one shared decoder, blanking gap between
// digits, frame-aligned double buffering. Define SEVEN_SEGMENT_SCAN_CTRL_LZB_EN for leading-zero blanking.
module seven_segment_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [15:0] BLANK_CYC = 16'd1000,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        dp_out,
  output logic [3:0]  an,
  output logic        frame_tick
);

  typedef enum logic {S_BLANK = 1'b0, S_SHOW = 1'b1} state_e;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 16'd1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 16'd1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [3:0]        shadow_dp_q, shadow_dp_d;
  logic              pending_q, pending_d;
  logic [3:0][3:0]   active_q, active_d;
  logic [3:0]        active_dp_q, active_dp_d;
  logic [3:0]        an_q, an_d;
  logic [3:0]        nib_q, nib_d;
  logic              dp_q, dp_d;
  logic              tick_q, tick_d;
  logic              boundary;
`ifdef SEVEN_SEGMENT_SCAN_CTRL_LZB_EN
  logic              lz;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_BLANK;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pending_q   <= 1'b0;
      active_q    <= '0;
      active_dp_q <= '0;
      an_q        <= 4'hF;
      nib_q       <= '0;
      dp_q        <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      an_q        <= an_d;
      nib_q       <= nib_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    nib_d       = nib_q;
    dp_d        = dp_q;
    an_d        = 4'hF;
    boundary    = 1'b0;
`ifdef SEVEN_SEGMENT_SCAN_CTRL_LZB_EN
    lz          = 1'b0;
`endif

    if (!en) begin
      // first_q makes the next BLANK exit land on digit 0 as a frame boundary
      state_d = S_BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
      first_d = 1'b1;
    end else begin
      case (state_q)
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            first_d = 1'b0;
            if (first_q || idx_q == 2'd3) begin
              idx_d    = 2'd0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    // Commit uses the pre-load shadow; a same-cycle load stays pending.
    if (boundary && pending_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
    end
    if (boundary) pending_d = 1'b0;
    if (load) begin
      shadow_d    = data_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end

    tick_d = boundary;
    if (state_d == S_SHOW) begin
      nib_d = active_d[idx_d];
      dp_d  = active_dp_d[idx_d];
      an_d  = ~(4'b0001 << idx_d);
`ifdef SEVEN_SEGMENT_SCAN_CTRL_LZB_EN
      lz = (idx_d != 2'd0) && !active_dp_d[idx_d];
      for (int i = 0; i < 4; i++)
        if (i >= int'(idx_d) && active_d[i] != 4'h0) lz = 1'b0;
      if (lz) an_d = 4'hF;
`endif
    end
  end

  assign {A, B, C, D} = nib_q;
  assign dp_out       = dp_q;
  assign an           = an_q;
  assign frame_tick   = tick_q;

endmodule

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
- Time-multiplexes one shared `seven_segment` decoder across a 4-digit common-anode display.
- Each slot presents one digit's nibble on the decoder inputs A,B,C,D and drives that digit's anode low.
- A blanking gap between slots prevents ghosting.
- New display data is double-buffered and applied only at frame boundaries, so a digit never tears mid-frame.

Parameters:
- SCAN_DIV, 16'd50000, clock cycles each digit is lit (SHOW); must be >= 1.
- BLANK_CYC, 16'd1000, clock cycles all anodes are off between digits (BLANK); must be >= 1.
- CNT_W, 16, width of the internal dwell counter; must hold max(SCAN_DIV, BLANK_CYC)-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 forces blanking.
- load  input  1  one-cycle strobe; captures data_in/dp_in into the shadow register.
- data_in  input  16  four BCD/hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  input  4  per-digit decimal point request, bit i maps to digit i.
- A, B, C, D  output  1 each  nibble to the decoder; A = bit3 (MSB) … D = bit0.
- dp_out  output  1  decimal point for the current digit, active-high.
- an  output  4  digit anodes, active-low; at most one bit low at any time.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset values:
  - State = BLANK, idx = 0, cnt = 0.
  - an = 4'b1111; A, B, C, D = 0; dp_out = 0; frame_tick = 0.
  - Shadow, active and pending registers all cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM has two states, SHOW and BLANK; cnt counts dwell cycles in the current state.
- SHOW:
  - an[idx] = 0, other anode bits = 1.
  - {A,B,C,D} = active[4*idx+3 : 4*idx]; dp_out = active_dp[idx].
  - When cnt == SCAN_DIV-1: go to BLANK, cnt = 0.
- BLANK:
  - an = 4'b1111; A, B, C, D and dp_out hold their last values.
  - When cnt == BLANK_CYC-1: idx = idx+1 (wraps 3 -> 0), go to SHOW, cnt = 0.
- Frame boundary (BLANK -> SHOW with idx wrapping 3 -> 0):
  - frame_tick pulses for that one cycle.
  - If pending = 1: active <= shadow, active_dp <= shadow_dp, pending <= 0.
- Load handling:
  - load = 1 captures data_in/dp_in into the shadow register and sets pending.
  - Back-to-back loads: the latest value wins.
  - Load in the same cycle as a boundary: the boundary commits the previous shadow; the new load stays pending for the next frame.
- Frame period = 4*(SCAN_DIV+BLANK_CYC) cycles. Digit order is 0, 1, 2, 3, 0, …
- The first frame after reset (with en = 1):
  - Starts with digit 0 after one BLANK period.
  - The initial BLANK -> SHOW(0) transition counts as a frame boundary: frame_tick pulses and pending data commits.
- en = 0:
  - Next cycle: state = BLANK, idx = 0, cnt = 0, an = 4'b1111; counter frozen.
  - Loads are still accepted into the shadow register.
  - When en returns to 1, the BLANK -> SHOW(0) exit is a frame boundary (commit + frame_tick).
- Reset asserted mid-frame returns everything to reset values immediately (asynchronous); shadow/pending data is lost.

Optional Feature:
- Macro: SEVEN_SEGMENT_SCAN_CTRL_LZB_EN (leading-zero blanking).
- Defined:
  - During SHOW of digit i (i = 3..1), an stays 4'b1111 if active nibbles i..3 are all zero and active_dp[i] = 0.
  - Digit 0 is always lit.
  - Slot timing is unchanged.
- Undefined: all four digits are always lit in their SHOW slots.

Test Plan:
- Reset/first frame (SCAN_DIV=4, BLANK_CYC=2): hold rst, then release with en=1 -> an=1111 for 2 cycles, then frame_tick pulses and an=1110 for 4 cycles, then 1111 for 2 cycles, then an=1101.
- Load data_in=16'h1234, dp_in=4'b0100 mid-frame -> current frame still shows old data. From the next frame_tick: digit 0 shows A..D=0100, digit 2 shows 0010 with dp_out=1, digit 3 shows 0001.
- Issue load 16'hAAAA, then load 16'h5555 in the same frame -> the next frame shows 5 on all four digits; AAAA is never displayed.
- Drop en=0 while in SHOW of digit 2 -> an=1111 on the next cycle. Raise en after 10 cycles -> BLANK for 2 cycles, then frame_tick, then digit 0 lit.
- Assert rst mid-SHOW -> an=1111, A..D=0, frame_tick=0 immediately, without waiting for a clock edge.
- With LZB_EN defined, load 16'h0042 -> an stays 1111 in the digit 3 and 2 slots, goes 1101 in the digit 1 slot and 1110 in the digit 0 slot. Load 16'h0000 -> only digit 0 lit, showing 0.
